control_sequencer: RTL and testbench

Multi-cycle control unit that replaces the VIO as the driver of the ALU/regfile/data-memory datapath. It fetches 16-bit instructions over a request/acknowledge port, decodes them, and sequences the datapath control lines (register addresses, ALU op, operand selects, immediate, write enables, write-back select) through FETCH/DECODE/EXECUTE/MEM/WB. It consumes the ALU's `take_branch` and `ovf` flags and owns the program counter.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/ctrl_decode.sv | 50 +++++
 rtl/control_sequencer.sv | 152 +++++++++++++++
 tb/tb_control_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU selects, FSM states,
// instruction field positions and the decoded-control bundle.
package ctrl_pkg;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_ADDI = 4'h1;
  localparam logic [3:0] OP_LW   = 4'h2;
  localparam logic [3:0] OP_SW   = 4'h3;
  localparam logic [3:0] OP_BEQ  = 4'h4;
  localparam logic [3:0] OP_J    = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_BEQ = 4'h8;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RS_MSB  = 11;
  localparam int RS_LSB  = 9;
  localparam int RT_MSB  = 8;
  localparam int RT_LSB  = 6;
  localparam int RD_MSB  = 5;
  localparam int RD_LSB  = 3;
  localparam int FN_MSB  = 2;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 5;
  localparam int IMM_LSB = 0;
  localparam int TGT_MSB = 11;
  localparam int TGT_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } ctrl_state_t;

  typedef struct packed {
    logic [2:0]  rd0_addr;
    logic [2:0]  rd1_addr;
    logic [2:0]  wr_addr;
    logic [3:0]  alu_op;
    logic        alu_src2;
    logic [15:0] imm;
    logic        mem_to_reg;
    logic        is_wb;
    logic        is_lw;
    logic        is_sw;
    logic        is_beq;
    logic        is_j;
    logic        is_halt;
    logic        illegal;
  } ctrl_bundle_t;

  function automatic logic [15:0] sext_imm6(input logic [5:0] v);
    return {{10{v[5]}}, v};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: 16-bit instruction word to decoded-control bundle.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [15:0]  instr,
  output ctrl_bundle_t ctrl
);

  logic [3:0] op;

  assign op = instr[OP_MSB:OP_LSB];

  always_comb begin
    ctrl          = '0;
    ctrl.rd0_addr = instr[RS_MSB:RS_LSB];
    ctrl.rd1_addr = instr[RT_MSB:RT_LSB];
    ctrl.wr_addr  = instr[RT_MSB:RT_LSB];
    ctrl.alu_op   = ALU_ADD;
    ctrl.imm      = sext_imm6(instr[IMM_MSB:IMM_LSB]);
    case (op)
      OP_R: begin
        ctrl.alu_op  = {1'b0, instr[FN_MSB:FN_LSB]};
        ctrl.wr_addr = instr[RD_MSB:RD_LSB];
        ctrl.is_wb   = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_src2 = 1'b1;
        ctrl.is_wb    = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src2   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.is_lw      = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src2 = 1'b1;
        ctrl.is_sw    = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_BEQ;
        ctrl.is_beq = 1'b1;
      end
      OP_J:    ctrl.is_j    = 1'b1;
      OP_HALT: ctrl.is_halt = 1'b1;
      // Undefined opcodes fall through the FSM as a NOP.
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer driving the ALU/regfile/data-memory datapath.
// Optional build macro CTRL_OVF_TRAP_EN: ALU overflow on R/ADDI halts instead of writing back.
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  input  logic            take_branch,
  input  logic            alu_ovf,
  output logic [2:0]      rd0_addr,
  output logic [2:0]      rd1_addr,
  output logic [2:0]      wr_addr,
  output logic [3:0]      alu_op,
  output logic            alu_src1,
  output logic            alu_src2,
  output logic [15:0]     imm,
  output logic            reg_write,
  output logic            mem_write,
  output logic            mem_to_reg,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     retired,
  output logic            halted,
  output logic            illegal
);

  ctrl_state_t     state;
  logic [15:0]     instr;
  ctrl_bundle_t    dec;
  ctrl_bundle_t    ctrl_q;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] pc_br;
  logic [PC_W-1:0] pc_jmp;
  logic            ovf_trap;

  ctrl_decode u_decode (
    .instr (instr),
    .ctrl  (dec)
  );

`ifdef CTRL_OVF_TRAP_EN
  assign ovf_trap = alu_ovf;
`else
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
  assign ovf_trap   = 1'b0;
`endif

  // Next-PC candidates; all arithmetic wraps modulo 2^PC_W.
  assign pc_seq = pc + PC_W'(1);
  assign pc_br  = pc_seq + PC_W'(ctrl_q.imm);
  assign pc_jmp = PC_W'(instr[TGT_MSB:TGT_LSB]);

  assign imem_addr  = pc;
  assign rd0_addr   = ctrl_q.rd0_addr;
  assign rd1_addr   = ctrl_q.rd1_addr;
  assign wr_addr    = ctrl_q.wr_addr;
  assign alu_op     = ctrl_q.alu_op;
  assign alu_src1   = 1'b0;
  assign alu_src2   = ctrl_q.alu_src2;
  assign imm        = ctrl_q.imm;
  assign mem_to_reg = ctrl_q.mem_to_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      pc        <= '0;
      instr     <= '0;
      ctrl_q    <= '0;
      retired   <= '0;
      imem_req  <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr    <= imem_data;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          ctrl_q <= dec;
          state  <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (ctrl_q.is_halt) begin
            state   <= S_HALT;
            halted  <= 1'b1;
            retired <= retired + 16'd1;
          end else if (ctrl_q.is_lw || ctrl_q.is_sw) begin
            state     <= S_MEM;
            mem_write <= ctrl_q.is_sw;
          end else if (ctrl_q.is_wb && ovf_trap) begin
            // Trapped instruction is not counted as retired.
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (ctrl_q.is_wb) begin
            state     <= S_WB;
            reg_write <= 1'b1;
          end else begin
            if (ctrl_q.is_j)
              pc <= pc_jmp;
            else if (ctrl_q.is_beq && take_branch)
              pc <= pc_br;
            else
              pc <= pc_seq;
            if (ctrl_q.illegal)
              illegal <= 1'b1;
            state    <= S_FETCH;
            imem_req <= 1'b1;
            retired  <= retired + 16'd1;
          end
        end
        S_MEM: begin
          mem_write <= 1'b0;
          if (ctrl_q.is_lw) begin
            state     <= S_WB;
            reg_write <= 1'b1;
          end else begin
            pc       <= pc_seq;
            state    <= S_FETCH;
            imem_req <= 1'b1;
            retired  <= retired + 16'd1;
          end
        end
        S_WB: begin
          reg_write <= 1'b0;
          pc        <= pc_seq;
          state     <= S_FETCH;
          imem_req  <= 1'b1;
          retired   <= retired + 16'd1;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed instructions queue expected fetch
// addresses and write-enable pulses; a monitor pops and compares as the DUT presents them.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam int PC_W = 8;

  logic            clk;
  logic            reset_n;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic            take_branch;
  logic            alu_ovf;
  logic [2:0]      rd0_addr;
  logic [2:0]      rd1_addr;
  logic [2:0]      wr_addr;
  logic [3:0]      alu_op;
  logic            alu_src1;
  logic            alu_src2;
  logic [15:0]     imm;
  logic            reg_write;
  logic            mem_write;
  logic            mem_to_reg;
  logic [PC_W-1:0] pc;
  logic [15:0]     retired;
  logic            halted;
  logic            illegal;

  control_sequencer #(.PC_W(PC_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .take_branch (take_branch),
    .alu_ovf     (alu_ovf),
    .rd0_addr    (rd0_addr),
    .rd1_addr    (rd1_addr),
    .wr_addr     (wr_addr),
    .alu_op      (alu_op),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .imm         (imm),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .pc          (pc),
    .retired     (retired),
    .halted      (halted),
    .illegal     (illegal)
  );

  typedef struct {
    int          cyc;
    logic [2:0]  rd0;
    logic [2:0]  rd1;
    logic [2:0]  wr;
    logic [3:0]  op;
    logic        src2;
    logic [15:0] imm;
    logic        m2r;
  } wb_t;

  typedef struct {
    int          cyc;
    logic [2:0]  rd0;
    logic [2:0]  rd1;
    logic [15:0] imm;
  } mw_t;

  int  fa_q[$];
  wb_t wb_q[$];
  mw_t mw_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h with nothing expected at %0t", nm, act, $time);
  endtask

  task automatic push_wb(input int c, input logic [2:0] r0, input logic [2:0] r1,
                         input logic [2:0] w, input logic [3:0] op, input logic s2,
                         input logic [15:0] im, input logic m2r);
    wb_t e;
    e.cyc = c; e.rd0 = r0; e.rd1 = r1; e.wr = w; e.op = op;
    e.src2 = s2; e.imm = im; e.m2r = m2r;
    wb_q.push_back(e);
  endtask

  task automatic push_mw(input int c, input logic [2:0] r0, input logic [2:0] r1,
                         input logic [15:0] im);
    mw_t e;
    e.cyc = c; e.rd0 = r0; e.rd1 = r1; e.imm = im;
    mw_q.push_back(e);
  endtask

  task automatic wait_req(input string nm);
    int n;
    n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(imem_req), 32'd1);
  endtask

  // Acknowledge the pending fetch after dly stall cycles; junk data is shown while ack is low.
  task automatic issue(input logic [15:0] w, input int dly);
    wait_req("fetch_req_seen");
    imem_data = 16'hF000;
    repeat (dly) @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = w;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 16'h0000;
  endtask

  // Monitor: fetch starts, reg_write and mem_write pulses are matched against the queues.
  logic req_prev = 1'b0;
  int   c0 = 0;
  initial begin
    wb_t ew;
    mw_t em;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        req_prev = 1'b0;
      end else begin
        if (imem_req && !req_prev) begin
          c0 = cyc;
          if (fa_q.size() == 0) fail("unexpected_fetch", 32'(imem_addr));
          else chk("fetch_addr", 32'(imem_addr), 32'(fa_q.pop_front()));
        end
        req_prev = imem_req;
        if (reg_write) begin
          if (wb_q.size() == 0) begin
            fail("unexpected_reg_write", 32'(wr_addr));
          end else begin
            ew = wb_q.pop_front();
            chk("wb_cycle",      32'(cyc - c0 + 1), 32'(ew.cyc));
            chk("wb_rd0_addr",   32'(rd0_addr),     32'(ew.rd0));
            chk("wb_rd1_addr",   32'(rd1_addr),     32'(ew.rd1));
            chk("wb_wr_addr",    32'(wr_addr),      32'(ew.wr));
            chk("wb_alu_op",     32'(alu_op),       32'(ew.op));
            chk("wb_alu_src1",   32'(alu_src1),     32'd0);
            chk("wb_alu_src2",   32'(alu_src2),     32'(ew.src2));
            chk("wb_imm",        32'(imm),          32'(ew.imm));
            chk("wb_mem_to_reg", 32'(mem_to_reg),   32'(ew.m2r));
            chk("wb_no_mem_write", 32'(mem_write),  32'd0);
          end
        end
        if (mem_write) begin
          if (mw_q.size() == 0) begin
            fail("unexpected_mem_write", 32'(rd0_addr));
          end else begin
            em = mw_q.pop_front();
            chk("mw_cycle",    32'(cyc - c0 + 1), 32'(em.cyc));
            chk("mw_rd0_addr", 32'(rd0_addr),     32'(em.rd0));
            chk("mw_rd1_addr", 32'(rd1_addr),     32'(em.rd1));
            chk("mw_imm",      32'(imm),          32'(em.imm));
            chk("mw_alu_src2", 32'(alu_src2),     32'd1);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_data   = 16'h0000;
    take_branch = 1'b0;
    alu_ovf     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_imem_req",  32'(imem_req),  32'd0);
    chk("rst_pc",        32'(pc),        32'd0);
    chk("rst_retired",   32'(retired),   32'd0);
    chk("rst_halted",    32'(halted),    32'd0);
    chk("rst_illegal",   32'(illegal),   32'd0);
    chk("rst_reg_write", 32'(reg_write), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_imm",       32'(imm),       32'd0);

    fa_q.push_back(0);
    reset_n = 1'b1;

    // R-type add r3 = r1 + r2, immediate ack
    push_wb(4, 3'd1, 3'd2, 3'd3, 4'h0, 1'b0, 16'h0018, 1'b0);
    fa_q.push_back(1);
    issue(16'h0298, 0);
    wait_req("r_next_fetch");
    chk("r_pc",      32'(pc),      32'd1);
    chk("r_retired", 32'(retired), 32'd1);

    // LW r1 = mem[r0 - 1], ack delayed two cycles
    push_wb(7, 3'd0, 3'd1, 3'd1, 4'h0, 1'b1, 16'hFFFF, 1'b1);
    fa_q.push_back(2);
    issue(16'h207F, 2);
    wait_req("lw_next_fetch");
    chk("lw_retired", 32'(retired), 32'd2);

    // SW mem[r2 + 5] = r3, one stall
    push_mw(5, 3'd2, 3'd3, 16'h0005);
    fa_q.push_back(3);
    issue(16'h34C5, 1);
    wait_req("sw_next_fetch");
    chk("sw_pc", 32'(pc), 32'd3);

    // ADDI r4 = r1 - 2
    push_wb(4, 3'd1, 3'd4, 3'd4, 4'h0, 1'b1, 16'hFFFE, 1'b0);
    fa_q.push_back(4);
    issue(16'h133E, 0);
    wait_req("addi_next_fetch");

    // R-type funct 5 into r5
    push_wb(4, 3'd2, 3'd3, 3'd5, 4'h5, 1'b0, 16'hFFED, 1'b0);
    fa_q.push_back(5);
    issue(16'h04ED, 0);
    wait_req("r5_next_fetch");

    // BEQ +3 at pc 5, taken
    take_branch = 1'b1;
    fa_q.push_back(9);
    issue(16'h4003, 0);
    @(negedge clk);
    chk("beq_alu_op",   32'(alu_op),   32'h8);
    chk("beq_alu_src2", 32'(alu_src2), 32'd0);
    chk("beq_imm",      32'(imm),      32'h0003);
    wait_req("beq_taken_fetch");
    chk("beq_taken_pc", 32'(pc), 32'd9);

    // BEQ +3 at pc 9, flag low on the EXECUTE edge
    fa_q.push_back(10);
    issue(16'h4003, 0);
    take_branch = 1'b0;
    wait_req("beq_nt_fetch");
    chk("beq_nt_pc", 32'(pc), 32'd10);

    // J to 0xFF, then an undefined opcode wraps pc to 0
    fa_q.push_back(8'hFF);
    issue(16'h50FF, 0);
    wait_req("j_fetch");
    chk("j_pc", 32'(pc), 32'hFF);
    fa_q.push_back(0);
    issue(16'h7000, 0);
    wait_req("nop_fetch");
    chk("nop_illegal", 32'(illegal), 32'd1);
    chk("nop_pc_wrap", 32'(pc),      32'd0);

    push_wb(4, 3'd1, 3'd2, 3'd3, 4'h0, 1'b0, 16'h0018, 1'b0);
    fa_q.push_back(1);
    issue(16'h0298, 0);
    wait_req("r2_next_fetch");
    chk("illegal_sticky", 32'(illegal), 32'd1);
    chk("retired_10",     32'(retired), 32'd10);

    // SW aborted by reset in its MEM cycle
    issue(16'h34C5, 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_mem_write_before", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_pc",        32'(pc),        32'd0);
    chk("abort_imem_req",  32'(imem_req),  32'd0);
    chk("abort_retired",   32'(retired),   32'd0);
    chk("abort_illegal",   32'(illegal),   32'd0);
    fa_q.push_back(0);
    @(negedge clk);
    reset_n = 1'b1;

    // ADDI r2 = r0 + 1 with ALU overflow flagged
    alu_ovf = 1'b1;
`ifdef CTRL_OVF_TRAP_EN
    issue(16'h1081, 0);
    repeat (6) @(negedge clk);
    chk("trap_halted",    32'(halted),    32'd1);
    chk("trap_imem_req",  32'(imem_req),  32'd0);
    chk("trap_retired",   32'(retired),   32'd0);
    chk("trap_reg_write", 32'(reg_write), 32'd0);
    alu_ovf = 1'b0;
`else
    push_wb(4, 3'd0, 3'd2, 3'd2, 4'h0, 1'b1, 16'h0001, 1'b0);
    fa_q.push_back(1);
    issue(16'h1081, 0);
    wait_req("ovf_ignored_fetch");
    alu_ovf = 1'b0;
    chk("ovf_ignored_retired", 32'(retired), 32'd1);
    issue(16'hF000, 0);
    repeat (4) @(negedge clk);
    chk("halt_halted",   32'(halted),   32'd1);
    chk("halt_imem_req", 32'(imem_req), 32'd0);
    chk("halt_retired",  32'(retired),  32'd2);
    chk("halt_pc",       32'(pc),       32'd1);
`endif

    repeat (3) @(negedge clk);
    chk("fa_q_drained", 32'(fa_q.size()), 32'd0);
    chk("wb_q_drained", 32'(wb_q.size()), 32'd0);
    chk("mw_q_drained", 32'(mw_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
